beta_prefetch_buffer: RTL



---
 rtl/beta_prefetch_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/beta_prefetch_buffer.sv
// beta_prefetch_buffer: instruction prefetch queue between the memory port
// and the fetch stage. Issues sequential word fetches ahead of the core,
// queues in-order responses and flushes on a branch/jump redirect.
//
// Optional build macro BETA_PREFETCH_BYPASS_EN: when defined, a response that
// arrives while the queue is empty (and is not being discarded) is presented
// on the fetch outputs in the same cycle, and is not queued if it is consumed.
//
// Handshake semantics: a memory request transfers when instr_req_o &
// instr_ready_i; instr_addr_o is held while the request waits, except that a
// branch withdraws it. A fetch pop transfers when fetch_valid_o &
// fetch_ready_i; the head is held until popped or flushed by a branch.
module beta_prefetch_buffer #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [AddressWidth-1:0] BootAddr = '0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic                    branch_i,
    input  logic [AddressWidth-1:0] branch_addr_i,
    output logic                    instr_req_o,
    output logic [AddressWidth-1:0] instr_addr_o,
    input  logic                    instr_ready_i,
    input  logic                    instr_valid_i,
    input  logic [DataWidth-1:0]    instr_rdata_i,
    output logic                    fetch_valid_o,
    output logic [DataWidth-1:0]    fetch_rdata_o,
    output logic [AddressWidth-1:0] fetch_addr_o,
    input  logic                    fetch_ready_i,
    output logic                    busy_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam logic [CW:0] DEPTH_C   = (CW + 1)'(Depth);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MaxOutstanding);
    localparam logic [AddressWidth-1:0] WORD_C  = AddressWidth'(4);
    localparam logic [AddressWidth-1:0] ALIGN_C = ~AddressWidth'(3);

    typedef struct packed {
        logic [DataWidth-1:0]    data;
        logic [AddressWidth-1:0] addr;
    } entry_t;

    entry_t                  mem_q [Depth];
    entry_t                  mem_d [Depth];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           discard_q, discard_d;
    logic [AddressWidth-1:0] req_ptr_q, req_ptr_d;
    logic [AddressWidth-1:0] rsp_ptr_q, rsp_ptr_d;

    logic fifo_empty, fifo_full;
    logic grant, rsp_accept, rsp_keep, bypass;
    logic push, pop;
    logic [AddressWidth-1:0] target;

    // Issue, response classification, queue head selection and next state.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = ({1'b0, count_q} == DEPTH_C);
        target     = branch_addr_i & ALIGN_C;

        // Counting granted-but-unanswered words against free slots keeps
        // the queue from ever overflowing.
        instr_req_o = en_i & ~branch_i & (outstanding_q < MAX_OUT_C) &
                      (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C);
        instr_addr_o = req_ptr_q;
        grant        = instr_req_o & instr_ready_i;
        busy_o       = instr_req_o | (outstanding_q != '0);

        // Responses with nothing outstanding are strays (e.g. after reset).
        rsp_accept = instr_valid_i & (outstanding_q != '0);
        rsp_keep   = rsp_accept & (discard_q == '0) & ~branch_i;
`ifdef BETA_PREFETCH_BYPASS_EN
        bypass = rsp_keep & fifo_empty;
`else
        bypass = 1'b0;
`endif

        fetch_valid_o = ~fifo_empty | bypass;
        if (bypass) begin
            fetch_rdata_o = instr_rdata_i;
            fetch_addr_o  = rsp_ptr_q;
        end else if (fifo_empty) begin
            fetch_rdata_o = '0;
            fetch_addr_o  = rsp_ptr_q;
        end else begin
            fetch_rdata_o = mem_q[rd_ptr_q].data;
            fetch_addr_o  = mem_q[rd_ptr_q].addr;
        end

        // A bypassed word that is taken immediately never enters the queue.
        pop  = fetch_valid_o & fetch_ready_i & ~branch_i & ~fifo_empty;
        push = rsp_keep & ~(bypass & fetch_ready_i);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{data: instr_rdata_i, addr: rsp_ptr_q};
        end

        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        count_d       = count_q + CW'(push) - CW'(pop);
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_accept);
        discard_d     = discard_q - CW'(rsp_accept & (discard_q != '0));
        req_ptr_d     = grant ? req_ptr_q + WORD_C : req_ptr_q;
        rsp_ptr_d     = rsp_keep ? rsp_ptr_q + WORD_C : rsp_ptr_q;

        // Redirect: drop the queue and every response still in flight.
        if (branch_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            discard_d = outstanding_q - CW'(rsp_accept);
            req_ptr_d = target;
            rsp_ptr_d = target;
        end
    end

    // State registers; reset drops every queued word and in-flight count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            req_ptr_q     <= BootAddr;
            rsp_ptr_q     <= BootAddr;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            req_ptr_q     <= req_ptr_d;
            rsp_ptr_q     <= rsp_ptr_d;
        end
    end

    // The issue rule makes this unreachable; it guards against regressions.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push && fifo_full));

endmodule
